// File: rtl/regfile_ctrl_pkg.sv
// Shared types and instruction-field layout for the regfile sequencing controller.
// Also holds the small decode helpers used by the FSM and the ALU.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_AND  = 3'b011,
        OP_MVN  = 3'b100
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RN_MSB  = 9;
    localparam int RN_LSB  = 7;
    localparam int RM_MSB  = 6;
    localparam int RM_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic [2:0] f_op(input logic [15:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] ins);
        return ins[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [2:0] f_rn(input logic [15:0] ins);
        return ins[RN_MSB:RN_LSB];
    endfunction

    function automatic logic [2:0] f_rm(input logic [15:0] ins);
        return ins[RM_MSB:RM_LSB];
    endfunction

    function automatic logic [15:0] f_imm_sext(input logic [15:0] ins);
        return {{8{ins[IMM_MSB]}}, ins[IMM_MSB:IMM_LSB]};
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return (op <= OP_MVN);
    endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Bundle of the controller's request/status signals and the regfile port.
// master = controller side, slave = requester plus regfile side.
interface regfile_ctrl_if;
    logic        start;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  flags;
    logic [15:0] rf_data_in;
    logic [2:0]  rf_writenum;
    logic [2:0]  rf_readnum;
    logic        rf_write;
    logic [15:0] rf_data_out;

    modport master (
        input  start, instr, rf_data_out,
        output busy, done, err, flags,
               rf_data_in, rf_writenum, rf_readnum, rf_write
    );

    modport slave (
        output start, instr, rf_data_out,
        input  busy, done, err, flags,
               rf_data_in, rf_writenum, rf_readnum, rf_write
    );
endinterface

// File: rtl/regfile_ctrl_alu.sv
// Combinational datapath: MOV pass-through, ADD, AND, MVN plus {N,Z} flags.
// flag_en tells the FSM whether this opcode is allowed to update the flags.
module regfile_ctrl_alu
    import regfile_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        n,
    output logic        z,
    output logic        flag_en
);

    always_comb begin
        result  = b;
        flag_en = 1'b0;
        case (op)
            OP_ADD: begin
                result  = a + b;
                flag_en = 1'b1;
            end
            OP_AND: begin
                result  = a & b;
                flag_en = 1'b1;
            end
            OP_MVN: begin
                result  = ~b;
                flag_en = 1'b1;
            end
            default: result = b;
        endcase
    end

    assign n = result[15];
    assign z = (result == 16'h0000);

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer that executes one instruction against an external registered-read regfile.
//   state     | meaning
//   ST_IDLE   | waiting for start, instr latched on accept
//   ST_READ_A | present Rn to the regfile
//   ST_READ_B | present Rm, capture R[Rn] into operand A
//   ST_EXEC   | R[Rm] on rf_data_out, register result and flags
//   ST_WRITE  | write result (or sign-extended imm8) to Rd
//   ST_DONE   | one-cycle done pulse, err for illegal opcode
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    regfile_ctrl_if.master bus
);

    state_e      state_q, state_d;
    logic [15:0] instr_q;
    logic [15:0] a_q;
    logic [15:0] result_q;
    logic [1:0]  flags_q;

    logic [15:0] alu_result;
    logic        alu_n, alu_z, alu_flag_en;

    logic        busy, done, err, rf_write;
    logic [2:0]  rf_writenum, rf_readnum;
    logic [15:0] rf_data_in;

    regfile_ctrl_alu u_alu (
        .op      (f_op(instr_q)),
        .a       (a_q),
        .b       (bus.rf_data_out),
        .result  (alu_result),
        .n       (alu_n),
        .z       (alu_z),
        .flag_en (alu_flag_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            a_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start)
                instr_q <= bus.instr;
            if (state_q == ST_READ_B)
                a_q <= bus.rf_data_out;
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                if (alu_flag_en)
                    flags_q <= {alu_n, alu_z};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        rf_write    = 1'b0;
        rf_writenum = '0;
        rf_readnum  = '0;
        rf_data_in  = '0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    case (f_op(bus.instr))
                        OP_MOVI:        state_d = ST_WRITE;
                        OP_MOV, OP_MVN: state_d = ST_READ_B;
                        OP_ADD, OP_AND: state_d = ST_READ_A;
                        default:        state_d = ST_DONE;
                    endcase
                end
            end
            ST_READ_A: begin
                rf_readnum = f_rn(instr_q);
                state_d    = ST_READ_B;
            end
            ST_READ_B: begin
                rf_readnum = f_rm(instr_q);
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                rf_readnum = f_rm(instr_q);
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                rf_write    = 1'b1;
                rf_writenum = f_rd(instr_q);
                // MOVI skips EXEC, so its value comes straight from the latched instruction
                rf_data_in  = (f_op(instr_q) == OP_MOVI) ? f_imm_sext(instr_q) : result_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = !is_legal(f_op(instr_q));
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err         = err;
    assign bus.flags       = flags_q;
    assign bus.rf_write    = rf_write;
    assign bus.rf_writenum = rf_writenum;
    assign bus.rf_readnum  = rf_readnum;
    assign bus.rf_data_in  = rf_data_in;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to execute instr; sampled only in IDLE.
- instr  in  16  instruction word; [15:13] opcode, [12:10] Rd, [9:7] Rn, [6:4] Rm, [7:0] imm8.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when opcode illegal.
- flags  out  2  {N,Z} of last ALU result.
- rf_data_in  out  16  write data to regfile.
- rf_writenum  out  3  regfile write index.
- rf_readnum  out  3  regfile read index.
- rf_write  out  1  regfile write enable.
- rf_data_out  in  16  regfile read data; registered, valid the cycle after readnum is presented with rf_write=0.

Function
REQ-002 Opcodes SHALL be: 000 MOVI Rd=sign-extend(imm8); 001 MOV Rd=Rm; 010 ADD Rd=Rn+Rm; 011 AND Rd=Rn&Rm; 100 MVN Rd=~Rm; 101-111 illegal.
REQ-003 States SHALL be IDLE, READ_A, READ_B, EXEC, WRITE, DONE.
REQ-004 IDLE with start=1 SHALL latch instr and go: MOVI->WRITE; MOV/MVN->READ_B; ADD/AND->READ_A; illegal->DONE with err.
REQ-005 READ_A SHALL drive rf_readnum=Rn, rf_write=0; next READ_B.
REQ-006 READ_B SHALL drive rf_readnum=Rm, rf_write=0, capture rf_data_out into operand A at cycle end; next EXEC.
REQ-007 EXEC SHALL compute result from A and rf_data_out (=R[Rm]), register result and flags at cycle end; next WRITE.
REQ-008 WRITE SHALL drive rf_write=1, rf_writenum=Rd, rf_data_in=result (MOVI: sign-extended imm8); next DONE.
REQ-009 DONE SHALL assert done=1 for exactly one cycle, err=1 only for illegal opcode; next IDLE.
REQ-010 Latency from start-accept edge to done high SHALL be: MOVI 2, MOV/MVN 4, ADD/AND 5, illegal 1 cycles.
REQ-011 rf_write SHALL be 0 in every state except WRITE.
REQ-012 ADD SHALL be 16-bit modulo, carry discarded; Z=(result==0), N=result[15]; flags update only for ADD/AND/MVN.
REQ-013 start while busy=1 SHALL be ignored; instr changes after acceptance SHALL have no effect.
REQ-014 Rd equal to Rn or Rm SHALL read old values and write the new value (reads complete before WRITE).

Reset
REQ-015 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, flags=00, rf_write=0, rf_writenum=0, rf_readnum=0, rf_data_in=0.
REQ-016 Reset mid-operation SHALL abort without any regfile write; regfile contents are not reset by this block.

Structure
REQ-017 Opcode enum, state enum and field bit positions SHALL live in shared package regfile_ctrl_pkg.
REQ-018 Combinational ALU (ADD/AND/MVN/pass, flags) SHALL be sub-module regfile_ctrl_alu; regfile itself is instantiated outside this block.

Verification
REQ-019 Bench SHALL connect regfile_ctrl to the team regfile and cover:
- MOVI R3,#0x85 -> done 2 cycles after accept, R3=0xFF85, flags unchanged.
- R1=0x7FFF, R2=0x0001, ADD R0,R1,R2 -> R0=0x8000, N=1 Z=0, done at cycle 5.
- R4=0x00F0, AND R4,R4,R4 then MVN R5,R4 -> R4=0x00F0, R5=0xFF0F, N=1.
- opcode 110 -> done=1 err=1 one cycle after accept, rf_write never high.
- start pulsed during ADD busy -> ignored, exactly one done pulse.
- rst_n low during EXEC of ADD R6 -> IDLE at once, R6 unchanged, rf_write=0.
